pong_game_ctrl: RTL

- Frame-rate game controller for the Pong design; sits directly downstream of vga_sync and consumes its pixel_x, pixel_y and video_on.
- Once per frame it updates ball and paddle positions, detects wall and paddle collisions, and tracks lives through a serve/play/over state machine.
- Every clock it arbitrates which graphic object (ball, paddle, wall or background) owns the current pixel and drives a registered 3-bit rgb.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/pong_game_ctrl_if.sv | 31 +++
 rtl/pong_frame_tick.sv | 33 +++
 rtl/pong_game_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants for the Pong game controller: FSM state
//                encodings, colour codes, screen geometry and serve position.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // FSM state encodings (also driven out on the state port)
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_PLAY  = 2'b01;
    localparam logic [1:0] c_ST_SERVE = 2'b10;
    localparam logic [1:0] c_ST_OVER  = 2'b11;

    // Pixel colours, {r,g,b}
    localparam logic [2:0] c_BLACK = 3'b000;
    localparam logic [2:0] c_RED   = 3'b100;
    localparam logic [2:0] c_GREEN = 3'b010;
    localparam logic [2:0] c_BLUE  = 3'b001;

    // Screen geometry
    localparam int c_H_VIS    = 640;
    localparam int c_V_VIS    = 480;
    localparam int c_TICK_ROW = 481;

    // Serve / reset positions
    localparam logic [9:0] c_BALL_X0 = 10'd320;
    localparam logic [9:0] c_BALL_Y0 = 10'd240;
    localparam logic [9:0] c_PAD_Y0  = 10'd204;

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl_if
//  Description : Video timing, button and game-status bundle between the
//                environment (master) and the Pong game controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pong_game_ctrl_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       btn_up;
    logic       btn_down;
    logic       btn_start;
    logic [2:0] rgb;
    logic [1:0] state;
    logic [1:0] lives;
    logic       hit;
    logic       miss;

    modport master (
        output pixel_x, pixel_y, video_on, btn_up, btn_down, btn_start,
        input  rgb, state, lives, hit, miss
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, btn_up, btn_down, btn_start,
        output rgb, state, lives, hit, miss
    );
endinterface
`default_nettype wire

// File: rtl/pong_frame_tick.sv
`default_nettype none
// ============================================================================
//  Module      : pong_frame_tick
//  Description : One-cycle frame tick on the first clock where the scan
//                position reaches column 0 of the tick row. The scan position
//                may dwell for several clocks, so the match is edge-detected.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_frame_tick
    import pong_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [9:0] pixel_x,
    input  wire logic [9:0] pixel_y,
    output logic            tick
);

    logic w_match;
    logic r_match_q;

    assign w_match = (pixel_x == 10'd0) && (pixel_y == 10'(c_TICK_ROW));

    // Remember the previous match so a dwelling position ticks only once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_match_q <= 1'b0;
        else        r_match_q <= w_match;
    end

    assign tick = w_match && !r_match_q;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Frame-rate Pong controller. Moves ball and paddle once per
//                frame, resolves collisions, tracks lives through an
//                IDLE/PLAY/SERVE/OVER FSM and arbitrates the pixel colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int PAD_H     = 72,
    parameter int PAD_V     = 4,
    parameter int PAD_X_L   = 600,
    parameter int PAD_X_R   = 603,
    parameter int WALL_X_L  = 32,
    parameter int WALL_X_R  = 35,
    parameter int LIVES     = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pong_game_ctrl_if.slave  bus
);

    // 10-bit forms of the geometry so every comparison is width-matched
    localparam logic [9:0] c_BV       = 10'(BALL_V);
    localparam logic [9:0] c_BS_M1    = 10'(BALL_SIZE - 1);
    localparam logic [9:0] c_BS       = 10'(BALL_SIZE);
    localparam logic [9:0] c_BOT_LIM  = 10'(c_V_VIS - BALL_V);
    localparam logic [9:0] c_WALL_LIM = 10'(WALL_X_R + BALL_V);
    localparam logic [9:0] c_MISS_X   = 10'(c_H_VIS - BALL_SIZE);
    localparam logic [9:0] c_PV       = 10'(PAD_V);
    localparam logic [9:0] c_PH_M1    = 10'(PAD_H - 1);
    localparam logic [9:0] c_PAD_SPAN = 10'(PAD_H + PAD_V);
    localparam logic [9:0] c_V_VIS10  = 10'(c_V_VIS);
    localparam logic [9:0] c_PXL      = 10'(PAD_X_L);
    localparam logic [9:0] c_PXR      = 10'(PAD_X_R);
    localparam logic [9:0] c_WXL      = 10'(WALL_X_L);
    localparam logic [9:0] c_WXR      = 10'(WALL_X_R);
    localparam logic [1:0] c_LIVES    = 2'(LIVES);

    logic [1:0] r_state, w_state_nxt;
    logic [1:0] r_lives;
    logic [9:0] r_ball_x, r_ball_y, r_pad_y;
    logic       r_dx_pos, r_dy_pos;
    logic       r_start_q;
    logic [2:0] r_rgb;
    logic       r_hit, r_miss;

    logic       w_tick, w_start_re;
    logic       w_top, w_bot, w_wall, w_pad_hit, w_miss;
    logic       w_dx_nxt, w_dy_nxt;
    logic       w_recentre, w_ball_step, w_lose, w_reload, w_pad_en, w_ball_show;
    logic       w_in_ball, w_in_pad, w_in_wall;

    pong_frame_tick u_tick (
        .clk     (clk),
        .reset   (reset),
        .pixel_x (bus.pixel_x),
        .pixel_y (bus.pixel_y),
        .tick    (w_tick)
    );

    assign w_start_re = bus.btn_start && !r_start_q;

    // Collisions against pre-update positions; sums only on the larger side
    assign w_top     = r_ball_y <= c_BV;
    assign w_bot     = (r_ball_y + c_BS) >= c_BOT_LIM;
    assign w_wall    = r_ball_x <= c_WALL_LIM;
    assign w_pad_hit = r_dx_pos
                    && ((r_ball_x + c_BS_M1) >= c_PXL)
                    && ((r_ball_x + c_BS_M1) <= c_PXR)
                    && ((r_ball_y + c_BS_M1) >= r_pad_y)
                    && (r_ball_y <= (r_pad_y + c_PH_M1));
    assign w_miss    = (r_ball_x >= c_MISS_X) && !w_pad_hit;

    // Paddle bounce overrides the wall; top/bottom combine independently
    assign w_dx_nxt = w_pad_hit ? 1'b0 : (w_wall ? 1'b1 : r_dx_pos);
    assign w_dy_nxt = w_top ? 1'b1 : (w_bot ? 1'b0 : r_dy_pos);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start_re) w_state_nxt = c_ST_PLAY;
            c_ST_PLAY:  if (w_tick && w_miss)
                            w_state_nxt = (r_lives == 2'd1) ? c_ST_OVER : c_ST_SERVE;
            c_ST_SERVE: if (w_start_re) w_state_nxt = c_ST_PLAY;
            default:    if (w_start_re) w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM output strobes steering the datapath
    always_comb begin
        w_recentre  = 1'b0;
        w_ball_step = 1'b0;
        w_lose      = 1'b0;
        w_reload    = 1'b0;
        w_pad_en    = w_tick && (r_state != c_ST_OVER);
        w_ball_show = (r_state == c_ST_PLAY);
        case (r_state)
            c_ST_IDLE, c_ST_SERVE: w_recentre = w_start_re;
            c_ST_PLAY: begin
                w_ball_step = w_tick && !w_miss;
                w_lose      = w_tick && w_miss;
            end
            default:    w_reload = w_start_re;
        endcase
    end

    // Start button edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_start_q <= 1'b0;
        else        r_start_q <= bus.btn_start;
    end

    // Paddle motion: one button alone moves it, clamped at both limits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pad_y <= c_PAD_Y0;
        end else if (w_pad_en) begin
            if (bus.btn_up && !bus.btn_down && (r_pad_y >= c_PV))
                r_pad_y <= r_pad_y - c_PV;
            else if (bus.btn_down && !bus.btn_up && ((r_pad_y + c_PAD_SPAN) <= c_V_VIS10))
                r_pad_y <= r_pad_y + c_PV;
        end
    end

    // Ball position and direction: re-centre on serve, step on play ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ball_x <= c_BALL_X0;
            r_ball_y <= c_BALL_Y0;
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b1;
        end else if (w_recentre) begin
            r_ball_x <= c_BALL_X0;
            r_ball_y <= c_BALL_Y0;
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b1;
        end else if (w_ball_step) begin
            r_dx_pos <= w_dx_nxt;
            r_dy_pos <= w_dy_nxt;
            r_ball_x <= w_dx_nxt ? (r_ball_x + c_BV) : (r_ball_x - c_BV);
            r_ball_y <= w_dy_nxt ? (r_ball_y + c_BV) : (r_ball_y - c_BV);
        end
    end

    // Lives counter and one-cycle hit/miss pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lives <= c_LIVES;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_hit  <= w_ball_step && w_pad_hit;
            r_miss <= w_lose;
            if (w_lose)        r_lives <= r_lives - 2'd1;
            else if (w_reload) r_lives <= c_LIVES;
        end
    end

    assign w_in_ball = w_ball_show
                    && (bus.pixel_x >= r_ball_x) && (bus.pixel_x <= (r_ball_x + c_BS_M1))
                    && (bus.pixel_y >= r_ball_y) && (bus.pixel_y <= (r_ball_y + c_BS_M1));
    assign w_in_pad  = (bus.pixel_x >= c_PXL) && (bus.pixel_x <= c_PXR)
                    && (bus.pixel_y >= r_pad_y) && (bus.pixel_y <= (r_pad_y + c_PH_M1));
    assign w_in_wall = (bus.pixel_x >= c_WXL) && (bus.pixel_x <= c_WXR);

    // Registered pixel colour, ball over paddle over wall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              r_rgb <= c_BLACK;
        else if (!bus.video_on)  r_rgb <= c_BLACK;
        else if (w_in_ball)      r_rgb <= c_RED;
        else if (w_in_pad)       r_rgb <= c_GREEN;
        else if (w_in_wall)      r_rgb <= c_BLUE;
        else                     r_rgb <= c_BLACK;
    end

    assign bus.rgb   = r_rgb;
    assign bus.state = r_state;
    assign bus.lives = r_lives;
    assign bus.hit   = r_hit;
    assign bus.miss  = r_miss;

endmodule
`default_nettype wire
